// File: rtl/gate_row_apply.sv
// Applies a 2x2 complex fixed-point gate to one amplitude pair, fetching the
// two gate rows one at a time from an external combinational gate ROM.
module gate_row_apply #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DATA_W-1:0] in_amp,
  output logic                gate_addr,
  input  logic [4*DATA_W-1:0] gate_row,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DATA_W-1:0] out_amp
);

  localparam int PW = 2 * DATA_W;
  localparam int AW = 2 * DATA_W + 2;

  typedef enum logic [1:0] {IDLE, ROW0, ROW1, DONE} state_t;

  state_t              state;
  logic [4*DATA_W-1:0] amp_q;
  logic [DATA_W-1:0]   xr, xi, yr, yi;
  logic [DATA_W-1:0]   a0r, a0i, a1r, a1i;
  logic signed [AW-1:0] re_acc, im_acc;
  logic [2*DATA_W-1:0] row_res;

  function automatic logic signed [AW-1:0] mul(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic signed [PW-1:0] p;
    p = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    return {{2{p[PW-1]}}, p};
  endfunction

  // Floor-shift back to the operand format, clamping anything that no longer fits.
  function automatic logic [DATA_W-1:0] scale_sat(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] sh;
    sh = acc >>> FRAC_W;
    if ((&sh[AW-1:DATA_W-1]) || !(|sh[AW-1:DATA_W-1]))
      return sh[DATA_W-1:0];
    else if (sh[AW-1])
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  assign xr  = gate_row[4*DATA_W-1 -: DATA_W];
  assign xi  = gate_row[3*DATA_W-1 -: DATA_W];
  assign yr  = gate_row[2*DATA_W-1 -: DATA_W];
  assign yi  = gate_row[DATA_W-1 -: DATA_W];
  assign a0r = amp_q[4*DATA_W-1 -: DATA_W];
  assign a0i = amp_q[3*DATA_W-1 -: DATA_W];
  assign a1r = amp_q[2*DATA_W-1 -: DATA_W];
  assign a1i = amp_q[DATA_W-1 -: DATA_W];

  always_comb begin
    re_acc  = mul(xr, a0r) - mul(xi, a0i) + mul(yr, a1r) - mul(yi, a1i);
    im_acc  = mul(xr, a0i) + mul(xi, a0r) + mul(yr, a1i) + mul(yi, a1r);
    row_res = {scale_sat(re_acc), scale_sat(im_acc)};
  end

  // gate_addr is set one edge ahead so it is already 1 throughout ROW1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      gate_addr <= 1'b0;
      out_amp   <= '0;
      amp_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            amp_q    <= in_amp;
            in_ready <= 1'b0;
            state    <= ROW0;
          end
        end
        ROW0: begin
          out_amp[4*DATA_W-1 -: 2*DATA_W] <= row_res;
          gate_addr <= 1'b1;
          state     <= ROW1;
        end
        ROW1: begin
          out_amp[2*DATA_W-1 -: 2*DATA_W] <= row_res;
          gate_addr <= 1'b0;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_row_apply.sv
// Directed and randomized check of gate_row_apply against a plain-arithmetic
// complex matrix-vector reference model.
module tb_gate_row_apply;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_amp;
  logic         gate_addr;
  logic [127:0] gate_row;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_amp;

  logic [127:0] g0, g1;
  int assertions = 0;
  int failures = 0;

  localparam logic signed [95:0] MAXV = 96'sd2147483647;
  localparam logic signed [95:0] MINV = -96'sd2147483648;

  gate_row_apply #(.DATA_W(32), .FRAC_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_amp(in_amp), .gate_addr(gate_addr), .gate_row(gate_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_amp(out_amp)
  );

  always #5 clk = ~clk;
  assign gate_row = gate_addr ? g1 : g0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [95:0] comp(input logic [127:0] v, input int k);
    logic signed [31:0] t;
    t = v[127-32*k -: 32];
    return {{64{t[31]}}, t};
  endfunction

  function automatic logic [31:0] sat(input logic signed [95:0] v);
    logic signed [95:0] s;
    s = v >>> 16;
    if (s > MAXV) return 32'h7FFF_FFFF;
    if (s < MINV) return 32'h8000_0000;
    return s[31:0];
  endfunction

  // One output element: complex dot product of a gate row with (a0, a1).
  function automatic logic [63:0] rowDot(input logic [127:0] r, input logic [127:0] a);
    logic signed [95:0] re, im;
    re = comp(r,0)*comp(a,0) - comp(r,1)*comp(a,1) + comp(r,2)*comp(a,2) - comp(r,3)*comp(a,3);
    im = comp(r,0)*comp(a,1) + comp(r,1)*comp(a,0) + comp(r,2)*comp(a,3) + comp(r,3)*comp(a,2);
    return {sat(re), sat(im)};
  endfunction

  function automatic logic [127:0] refApply(input logic [127:0] a);
    return {rowDot(g0, a), rowDot(g1, a)};
  endfunction

  function automatic logic [31:0] rndComp();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(1) == 0) r = {{14{r[17]}}, r[17:0]};
    return r;
  endfunction

  function automatic logic [127:0] rndVec();
    return {rndComp(), rndComp(), rndComp(), rndComp()};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    assertions++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one pair, follows it through the row fetches, holds off the
  // result for 'hold' cycles while poking in_valid, then drains it.
  task automatic applyStimulus(input string tag, input logic [127:0] amp, input int hold);
    logic [127:0] exp;
    logic         ga_q[$];
    int           cnt;
    exp = refApply(amp);
    in_amp = amp;
    in_valid = 1'b1;
    cnt = 0;
    while (!in_ready && cnt < 10) begin step(); cnt++; end
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    in_amp = rndVec();
    cnt = 1;
    while (!out_valid && cnt < 8) begin
      ga_q.push_back(gate_addr);
      step();
      cnt++;
    end
    checkOutput({tag, "_latency"}, cnt, 3);
    checkOutput({tag, "_addr_seq"},
                (ga_q.size() == 2 && ga_q[0] == 1'b0 && ga_q[1] == 1'b1), 1);
    checkOutput({tag, "_addr_done"}, gate_addr, 0);
    checkOutput({tag, "_out_amp"}, out_amp, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      in_amp = rndVec();
      step();
      checkOutput({tag, "_hold_valid"}, out_valid, 1);
      checkOutput({tag, "_hold_amp"}, out_amp, exp);
      checkOutput({tag, "_hold_ready"}, in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput({tag, "_drain_valid"}, out_valid, 0);
    checkOutput({tag, "_drain_ready"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_amp = '0;
    g0 = '0;
    g1 = '0;
    step();
    step();
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_gate_addr", gate_addr, 0);
    checkOutput("reset_out_amp", out_amp, 0);
    rst = 1'b0;
    step();

    g0 = {32'h0001_0000, 32'h0, 32'h0, 32'h0};
    g1 = {32'h0, 32'h0, 32'h0001_0000, 32'h0};
    applyStimulus("identity", {32'h0001_0000, 32'h0, 32'h0, 32'hFFFF_8000}, 0);
    checkOutput("identity_passthru", out_amp, {32'h0001_0000, 32'h0, 32'h0, 32'hFFFF_8000});

    g0 = {32'h0000_B505, 32'h0, 32'h0000_B505, 32'h0};
    g1 = {32'h0000_B505, 32'h0, 32'hFFFF_4AFB, 32'h0};
    applyStimulus("hadamard_a0", {32'h0001_0000, 32'h0, 32'h0, 32'h0}, 0);
    applyStimulus("hadamard_a1", {32'h0, 32'h0, 32'h0001_0000, 32'h0}, 0);
    checkOutput("hadamard_a1_literal", out_amp,
                {32'h0000_B505, 32'h0, 32'hFFFF_4AFB, 32'h0});

    g0 = {32'h0, 32'h0, 32'h0001_0000, 32'h0};
    g1 = {32'h0001_0000, 32'h0, 32'h0, 32'h0};
    applyStimulus("pauli_x", {32'h0002_0000, 32'h0003_0000, 32'h0, 32'h0}, 0);

    g0 = {32'h7FFF_0000, 32'h0, 32'h7FFF_0000, 32'h0};
    g1 = g0;
    applyStimulus("sat_pos", {32'h7FFF_0000, 32'h0, 32'h7FFF_0000, 32'h0}, 0);
    g0 = {32'h8001_0000, 32'h0, 32'h8001_0000, 32'h0};
    g1 = g0;
    applyStimulus("sat_neg", {32'h7FFF_0000, 32'h0, 32'h7FFF_0000, 32'h0}, 0);

    g0 = {32'h0000_B505, 32'h0000_1000, 32'hFFFF_4AFB, 32'h0002_0000};
    g1 = {32'h0001_8000, 32'hFFFF_0000, 32'h0000_4000, 32'h0000_7000};
    applyStimulus("backpressure", {32'h0003_0000, 32'hFFFE_8000, 32'h0000_C000, 32'h0001_2345}, 5);
    applyStimulus("after_bp", {32'hFFFF_0000, 32'h0000_8000, 32'h0002_0000, 32'hFFFF_C000}, 0);

    // Reset while the second row is being fetched must discard the pair.
    in_amp = {32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checkOutput("midrst_in_row1", gate_addr, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_out_amp", out_amp, 0);
    checkOutput("midrst_gate_addr", gate_addr, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput("midrst_no_stale", out_valid, 0);
    end

    for (int n = 0; n < 24; n++) begin
      g0 = rndVec();
      g1 = rndVec();
      applyStimulus("random", rndVec(), $urandom_range(2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
